// File: rtl/ddr_arbiter_if.sv
// Requester and controller signal bundle for the DDR arbiter.
// master is the arbiter's view; slave is the requester/controller side.
interface ddr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 24
) ();
  logic                  initDone;
  logic                  dispReq;
  logic [ADDR_WIDTH-1:0] dispAddr;
  logic                  dispAck;
  logic [31:0]           dispData;
  logic                  drawReq;
  logic [ADDR_WIDTH-1:0] drawAddr;
  logic [31:0]           drawData;
  logic                  drawAck;
  logic                  ctrlReady;
  logic                  ctrlStart;
  logic [1:0]            ctrlOp;
  logic [ADDR_WIDTH-1:0] ctrlAddr;
  logic [31:0]           ctrlWriteData;
  logic                  ctrlDone;
  logic [31:0]           ctrlReadData;
  logic                  refreshOverrun;

  modport master (
    input  initDone, dispReq, dispAddr, drawReq, drawAddr, drawData,
           ctrlReady, ctrlDone, ctrlReadData,
    output dispAck, dispData, drawAck, ctrlStart, ctrlOp, ctrlAddr,
           ctrlWriteData, refreshOverrun
  );

  modport slave (
    output initDone, dispReq, dispAddr, drawReq, drawAddr, drawData,
           ctrlReady, ctrlDone, ctrlReadData,
    input  dispAck, dispData, drawAck, ctrlStart, ctrlOp, ctrlAddr,
           ctrlWriteData, refreshOverrun
  );
endinterface

// File: rtl/ddr_arbiter.sv
// Shares one DDR controller port between display reads, draw writes and periodic refresh,
// issuing one operation at a time through a start/done handshake.
module ddr_arbiter #(
  parameter int unsigned ADDR_WIDTH          = 24,
  parameter int unsigned REFRESH_INTERVAL    = 1037,
  parameter int unsigned MAX_PENDING_REFRESH = 8,
  parameter int unsigned FAIRNESS_LIMIT      = 4
) (
  input logic           clk133_p,
  input logic           rst,
  ddr_arbiter_if.master bus
);
  localparam int unsigned TW = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned CW = $clog2(MAX_PENDING_REFRESH + 1);
  localparam int unsigned FW = $clog2(FAIRNESS_LIMIT + 1);

  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_REFRESH = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                r_state, w_state_d;
  logic [TW-1:0]         r_timer;
  logic [CW-1:0]         r_credits;
  logic [FW-1:0]         r_fair, w_fair_d;
  logic [1:0]            r_op, w_op_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [31:0]           r_wdata, w_wdata_d;
  logic                  r_disp_ack, w_disp_ack_d;
  logic                  r_draw_ack, w_draw_ack_d;
  logic [31:0]           r_disp_data;
  logic                  r_overrun;
  logic                  w_load_rdata;
  logic                  w_credit_add, w_credit_use;

  assign w_credit_add = bus.initDone && (r_timer == '0);
  assign w_credit_use = (r_state == StIssue) && (r_op == OP_REFRESH);

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_fair_d     = r_fair;
    w_disp_ack_d = 1'b0;
    w_draw_ack_d = 1'b0;
    w_load_rdata = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.ctrlReady && bus.initDone) begin
          if (r_credits != '0) begin
            w_op_d    = OP_REFRESH;
            w_addr_d  = '0;
            w_wdata_d = '0;
            w_state_d = StIssue;
          end else if (bus.drawReq && (r_fair == FW'(FAIRNESS_LIMIT))) begin
            w_op_d    = OP_WRITE;
            w_addr_d  = bus.drawAddr;
            w_wdata_d = bus.drawData;
            w_fair_d  = '0;
            w_state_d = StIssue;
          end else if (bus.dispReq) begin
            w_op_d    = OP_READ;
            w_addr_d  = bus.dispAddr;
            w_wdata_d = '0;
            // Count display wins only while draw is actually waiting.
            if (!bus.drawReq) begin
              w_fair_d = '0;
            end else if (r_fair != FW'(FAIRNESS_LIMIT)) begin
              w_fair_d = r_fair + FW'(1);
            end
            w_state_d = StIssue;
          end else if (bus.drawReq) begin
            w_op_d    = OP_WRITE;
            w_addr_d  = bus.drawAddr;
            w_wdata_d = bus.drawData;
            w_fair_d  = '0;
            w_state_d = StIssue;
          end
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        if (bus.ctrlDone) begin
          w_disp_ack_d = (r_op == OP_READ);
          w_draw_ack_d = (r_op == OP_WRITE);
          w_load_rdata = (r_op == OP_READ);
          w_op_d       = OP_NONE;
          w_state_d    = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk133_p) begin
    if (rst) begin
      r_state     <= StIdle;
      r_timer     <= TW'(REFRESH_INTERVAL - 1);
      r_credits   <= '0;
      r_fair      <= '0;
      r_op        <= OP_NONE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_disp_ack  <= 1'b0;
      r_draw_ack  <= 1'b0;
      r_disp_data <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_fair     <= w_fair_d;
      r_op       <= w_op_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_disp_ack <= w_disp_ack_d;
      r_draw_ack <= w_draw_ack_d;
      if (w_load_rdata) begin
        r_disp_data <= bus.ctrlReadData;
      end
      if (bus.initDone) begin
        r_timer <= (r_timer == '0) ? TW'(REFRESH_INTERVAL - 1) : r_timer - TW'(1);
      end
      // Simultaneous add and consume cancel out.
      if (w_credit_add && !w_credit_use) begin
        if (r_credits == CW'(MAX_PENDING_REFRESH)) begin
          r_overrun <= 1'b1;
        end else begin
          r_credits <= r_credits + CW'(1);
        end
      end else if (w_credit_use && !w_credit_add) begin
        r_credits <= r_credits - CW'(1);
      end
    end
  end

  assign bus.ctrlStart      = (r_state == StIssue);
  assign bus.ctrlOp         = r_op;
  assign bus.ctrlAddr       = r_addr;
  assign bus.ctrlWriteData  = r_wdata;
  assign bus.dispAck        = r_disp_ack;
  assign bus.dispData       = r_disp_data;
  assign bus.drawAck        = r_draw_ack;
  assign bus.refreshOverrun = r_overrun;
endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter with a fixed-latency controller model (done 6 cycles after start).
module tb_ddr_arbiter;
  localparam int DONE_LAT = 6;

  typedef struct {
    int          cyc;
    logic [1:0]  op;
    logic [23:0] addr;
    logic [31:0] wd;
  } start_t;

  logic   clk = 1'b0;
  logic   rst;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     mdl_cnt = 0;
  int     n_draw_ack = 0;
  int     n_disp_ack = 0;
  start_t starts[$];

  ddr_arbiter_if #(.ADDR_WIDTH(24)) bus ();

  ddr_arbiter #(
    .ADDR_WIDTH(24),
    .REFRESH_INTERVAL(1037),
    .MAX_PENDING_REFRESH(8),
    .FAIRNESS_LIMIT(4)
  ) dut (
    .clk133_p(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model and start/ack monitor, both on the falling edge.
  always @(negedge clk) begin
    bus.ctrlDone = 1'b0;
    if (bus.ctrlStart) begin
      starts.push_back('{cyc, bus.ctrlOp, bus.ctrlAddr, bus.ctrlWriteData});
      mdl_cnt = DONE_LAT;
    end else if (mdl_cnt != 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) bus.ctrlDone = 1'b1;
    end
    if (bus.drawAck) n_draw_ack = n_draw_ack + 1;
    if (bus.dispAck) n_disp_ack = n_disp_ack + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_start"}, 64'(bus.ctrlStart), 0);
    chk({p, "_op"}, 64'(bus.ctrlOp), 0);
    chk({p, "_addr"}, 64'(bus.ctrlAddr), 0);
    chk({p, "_wdata"}, 64'(bus.ctrlWriteData), 0);
    chk({p, "_dispAck"}, 64'(bus.dispAck), 0);
    chk({p, "_drawAck"}, 64'(bus.drawAck), 0);
    chk({p, "_dispData"}, 64'(bus.dispData), 0);
    chk({p, "_overrun"}, 64'(bus.refreshOverrun), 0);
    chk({p, "_credits"}, 64'(dut.r_credits), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_starts(input int base, input int n, input int limit);
    for (int i = 0; i < limit && (starts.size() - base) < n; i++) tick();
  endtask

  initial begin
    int     base, c, t0, rel, ack_cyc, da0;
    bit     got;
    start_t s;
    logic [1:0] pat [10];
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    rst = 1'b1;
    bus.initDone = 1'b0;
    bus.dispReq = 1'b0;
    bus.dispAddr = '0;
    bus.drawReq = 1'b0;
    bus.drawAddr = '0;
    bus.drawData = '0;
    bus.ctrlReady = 1'b1;
    bus.ctrlReadData = '0;
    repeat (3) tick();
    chk_zero("rst");
    rst = 1'b0;

    // initDone low: no refresh, timer frozen at its load value.
    repeat (1100) tick();
    chk("init_gate_starts", 64'(starts.size()), 0);
    chk("init_gate_timer", 64'(dut.r_timer), 1036);

    // Test 1: refresh timing, nothing else issued.
    base = starts.size();
    bus.initDone = 1'b1;
    t0 = cyc;
    repeat (2100) tick();
    chk("t1_count", 64'(starts.size() - base), 2);
    s = starts[base];
    rel = s.cyc - t0 + 1;
    chk("t1_first_cycle", 64'((rel == 1038) || (rel == 1039)), 1);
    chk("t1_op0", 64'(s.op), 2'b11);
    chk("t1_addr0", 64'(s.addr), 0);
    chk("t1_period", 64'(starts[base + 1].cyc - s.cyc), 1037);
    chk("t1_op1", 64'(starts[base + 1].op), 2'b11);

    // Test 2: single display read.
    do_reset();
    base = starts.size();
    bus.ctrlReadData = 32'hAAAA5555;
    bus.dispAddr = 24'h000123;
    bus.dispReq = 1'b1;
    c = cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus.dispAck) got = 1'b1;
    end
    ack_cyc = cyc;
    bus.dispReq = 1'b0;
    chk("t2_ack_seen", 64'(got), 1);
    chk("t2_data", 64'(bus.dispData), 32'hAAAA5555);
    chk("t2_count", 64'(starts.size() - base), 1);
    s = starts[base];
    chk("t2_start_cycle", 64'(s.cyc - c), 1);
    chk("t2_op", 64'(s.op), 2'b01);
    chk("t2_addr", 64'(s.addr), 24'h000123);
    chk("t2_ack_latency", 64'(ack_cyc - s.cyc), DONE_LAT + 1);
    bus.ctrlReadData = 32'h0;
    repeat (5) tick();
    chk("t2_data_held", 64'(bus.dispData), 32'hAAAA5555);
    chk("t2_ack_pulse", 64'(bus.dispAck), 0);
    chk("t2_op_idle", 64'(bus.ctrlOp), 0);
    chk("t2_no_regrant", 64'(starts.size() - base), 1);

    // Test 3: fairness D D D D W D D D D W.
    do_reset();
    base = starts.size();
    da0 = n_draw_ack;
    bus.dispAddr = 24'h000456;
    bus.drawAddr = 24'h00BEEF;
    bus.drawData = 32'h12345678;
    bus.dispReq = 1'b1;
    bus.drawReq = 1'b1;
    wait_starts(base, 10, 200);
    bus.dispReq = 1'b0;
    bus.drawReq = 1'b0;
    repeat (20) tick();
    chk("t3_count", 64'(starts.size() - base), 10);
    for (int i = 0; i < 10; i++) begin
      s = starts[base + i];
      chk($sformatf("t3_op%0d", i), 64'(s.op), 64'(pat[i]));
      if (pat[i] == 2'b10) begin
        chk($sformatf("t3_waddr%0d", i), 64'(s.addr), 24'h00BEEF);
        chk($sformatf("t3_wdata%0d", i), 64'(s.wd), 32'h12345678);
      end
    end
    chk("t3_draw_acks", 64'(n_draw_ack - da0), 2);

    // Test 4: pending refresh beats both requesters.
    do_reset();
    bus.ctrlReady = 1'b0;
    repeat (1040) tick();
    chk("t4_credit", 64'(dut.r_credits), 1);
    base = starts.size();
    bus.dispReq = 1'b1;
    bus.drawReq = 1'b1;
    bus.ctrlReady = 1'b1;
    wait_starts(base, 2, 60);
    bus.dispReq = 1'b0;
    bus.drawReq = 1'b0;
    repeat (20) tick();
    chk("t4_op0", 64'(starts[base].op), 2'b11);
    chk("t4_op1", 64'(starts[base + 1].op), 2'b01);
    chk("t4_credits_zero", 64'(dut.r_credits), 0);

    // Test 5: credit saturation and overrun, then drain.
    do_reset();
    bus.ctrlReady = 1'b0;
    repeat (9 * 1037 + 5) tick();
    chk("t5_credits_sat", 64'(dut.r_credits), 8);
    chk("t5_overrun", 64'(bus.refreshOverrun), 1);
    base = starts.size();
    bus.dispReq = 1'b1;
    bus.ctrlReady = 1'b1;
    wait_starts(base, 9, 200);
    bus.dispReq = 1'b0;
    repeat (20) tick();
    chk("t5_count", 64'(starts.size() - base), 9);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_ref%0d", i), 64'(starts[base + i].op), 2'b11);
    end
    chk("t5_disp_after", 64'(starts[base + 8].op), 2'b01);
    chk("t5_overrun_sticky", 64'(bus.refreshOverrun), 1);

    // Test 6: reset during a write's WAIT abandons it.
    do_reset();
    base = starts.size();
    da0 = n_draw_ack;
    bus.drawAddr = 24'h000777;
    bus.drawData = 32'hCAFEF00D;
    bus.drawReq = 1'b1;
    wait_starts(base, 1, 20);
    repeat (2) tick();
    chk("t6_in_wait_op", 64'(bus.ctrlOp), 2'b10);
    rst = 1'b1;
    bus.drawReq = 1'b0;
    tick();
    chk_zero("t6");
    rst = 1'b0;
    repeat (20) tick();
    chk("t6_no_ack", 64'(n_draw_ack - da0), 0);
    chk("t6_no_restart", 64'(starts.size() - base), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
Sequencer and arbiter in front of the DDR command controller. It shares one DDR port between the display fetch (read) requester and the draw (write) requester, and generates periodic auto-refresh operations. Requests are serialized into single-operation start/done handshakes toward the controller, and read data is returned to the display requester.

Parameters:
ADDR_WIDTH, 24, word address width (row, bank and column packed by the controller)
REFRESH_INTERVAL, 1037, cycles between refresh credits (7.8 us at 133 MHz)
MAX_PENDING_REFRESH, 8, saturation limit of the refresh credit counter
FAIRNESS_LIMIT, 4, maximum consecutive display grants while draw is waiting

Ports:
clk133_p  in  1  system clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-high
initDone  in  1  controller power-up init finished; arbiter inert while low
dispReq  in  1  display read request; held until dispAck
dispAddr  in  ADDR_WIDTH  display read address; stable while dispReq is high
dispAck  out  1  one-cycle pulse: read complete, dispData valid
dispData  out  32  read data; held until the next dispAck
drawReq  in  1  draw write request; held until drawAck
drawAddr  in  ADDR_WIDTH  write address
drawData  in  32  write data
drawAck  out  1  one-cycle pulse: write complete
ctrlReady  in  1  controller idle and able to accept ctrlStart
ctrlStart  out  1  one-cycle operation start pulse
ctrlOp  out  2  00 none, 01 read, 10 write, 11 refresh
ctrlAddr  out  ADDR_WIDTH  operation address (0 for refresh)
ctrlWriteData  out  32  write data
ctrlDone  in  1  one-cycle pulse: operation finished; ctrlReadData valid for reads
ctrlReadData  in  32  read data from controller
refreshOverrun  out  1  sticky flag: a refresh credit was lost at saturation

Behaviour:
- Reset: all outputs 0. State IDLE. Refresh credits 0. Timer loaded with REFRESH_INTERVAL-1. Fairness count 0. Reset takes effect mid-operation; the in-flight op is abandoned and no ack is issued.
- When initDone is low: the timer holds its load value and no grants are made.
- Refresh timer: decrements each cycle while initDone is high. At 0 it reloads and adds one credit.
  - Credits saturate at MAX_PENDING_REFRESH. An add at saturation sets refreshOverrun, which stays set until rst.
  - An add and a consume in the same cycle leave the credit count unchanged.
- State machine IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: evaluated in cycle N only when ctrlReady=1 and initDone=1. Selection order:
    1. refresh if credits > 0;
    2. otherwise draw if drawReq and the fairness count equals FAIRNESS_LIMIT;
    3. otherwise display if dispReq;
    4. otherwise draw if drawReq.
  - The selected op, address and data are registered, and the state moves to ISSUE.
  - ISSUE (cycle N+1): ctrlStart=1 for exactly this cycle. ctrlOp, ctrlAddr and ctrlWriteData are valid and stay held until ctrlDone. A refresh credit is consumed at this edge. Next state is WAIT.
  - WAIT: hold until ctrlDone. If ctrlDone arrives in cycle M:
    - the matching ack pulses in cycle M+1;
    - for a read, dispData is loaded from ctrlReadData at the end of cycle M;
    - the state returns to IDLE in cycle M+1, and ctrlOp returns to 00.
  - A new decision can be made in cycle M+1, so the earliest next ctrlStart is M+2.
- Fairness count: increments on a display grant while drawReq=1, saturating at FAIRNESS_LIMIT. It clears on any draw grant, and clears on a display grant when drawReq=0.
- A ctrlDone received in IDLE or ISSUE is ignored.
- Requester input changes are sampled only at the IDLE decision. A requester that drops its request before being granted is simply not served.
- Simultaneous dispReq, drawReq and credit: refresh first, then display (subject to fairness), then draw.

Test Plan:
1. Reset then initDone=1, with a controller model whose ctrlReady is always high and ctrlDone arrives 6 cycles after start. Expect the first refresh ctrlStart (op 11) in the cycle after the 1037th counted cycle, and no other ctrlStart.
2. dispReq with dispAddr=0x000123 and the model returning 0xAAAA5555. Expect ctrlStart one cycle after the request with op 01 and addr 0x000123. Expect dispAck one cycle after ctrlDone with dispData=0xAAAA5555, held afterwards.
3. dispReq and drawReq held continuously with FAIRNESS_LIMIT=4. Expect the grant pattern D D D D W D D D D W. drawAck carries ctrlWriteData equal to drawData.
4. Refresh credit pending while both requests are high. Expect op 11 first, then display. The credit count returns to 0.
5. ctrlReady held low for 9*1037 cycles. Expect credits saturated at 8 and refreshOverrun=1. After ctrlReady rises, expect 8 consecutive refresh ops before any request is served.
6. Assert rst during WAIT of a write. Expect no drawAck, all outputs 0 the next cycle, and credits 0.
